// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds the FSM state and owner encodings plus the starvation counter helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

  localparam int STARVE_W = 4;

  function automatic logic [STARVE_W-1:0] satInc(input logic [STARVE_W-1:0] value,
                                                 input logic [STARVE_W-1:0] limit);
    return (value >= limit) ? limit : value + 1'b1;
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational grant decision: data wins unless a pending fetch has been
// passed over STARVE_LIMIT times in a row, in which case fetch is forced.
module arb_priority_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                d_req_i,
  input  logic                i_req_i,
  input  logic                flush_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  output logic                grant_data_o,
  output logic                grant_if_o
);

  logic ifPending;
  logic forceIf;

  // A flushed fetch is not a contender, so it can neither win nor force.
  always_comb begin
    ifPending    = i_req_i && !flush_i;
    forceIf      = ifPending && (starve_cnt_i == STARVE_W'(STARVE_LIMIT));
    grant_data_o = d_req_i && !forceIf;
    grant_if_o   = !grant_data_o && ifPending;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch port and
// the data port. All outputs are registered; busy is decoded from the state.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e          state_q;
  arb_owner_e          owner_q;
  logic                cancel_q;
  logic [STARVE_W-1:0] starveCnt_q;
  logic [STARVE_W-1:0] starveCnt_d;
  logic                iAck_q;
  logic                dAck_q;
  logic [DATA_W-1:0]   iRdata_q;
  logic [DATA_W-1:0]   dRdata_q;
  logic                memReq_q;
  logic                memWe_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [DATA_W-1:0]   memWdata_q;
  logic                grantData;
  logic                grantIf;

  arb_priority_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .d_req_i     (d_req),
    .i_req_i     (i_req),
    .flush_i     (flush),
    .starve_cnt_i(starveCnt_q),
    .grant_data_o(grantData),
    .grant_if_o  (grantIf)
  );

  // The counter only moves while arbitrating; a flushed fetch neither counts nor clears.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (state_q == IDLE) begin
      if (grantIf || !i_req) begin
        starveCnt_d = '0;
      end else if (grantData && !flush) begin
        starveCnt_d = satInc(starveCnt_q, STARVE_W'(STARVE_LIMIT));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_DATA;
      cancel_q    <= 1'b0;
      starveCnt_q <= '0;
      iAck_q      <= 1'b0;
      dAck_q      <= 1'b0;
      iRdata_q    <= '0;
      dRdata_q    <= '0;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      case (state_q)
        IDLE: begin
          if (grantData || grantIf) begin
            owner_q    <= grantData ? OWN_DATA : OWN_IF;
            memReq_q   <= 1'b1;
            memWe_q    <= grantData && d_we;
            memAddr_q  <= grantData ? d_addr : i_addr;
            memWdata_q <= grantData ? d_wdata : '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (flush && owner_q == OWN_IF) begin
            cancel_q <= 1'b1;
          end
          // A flush in the completing cycle still cancels, so it is folded in here.
          if (mem_ready) begin
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
            state_q  <= RESP;
            if (owner_q == OWN_DATA) begin
              dAck_q   <= 1'b1;
              dRdata_q <= memWe_q ? '0 : mem_rdata;
            end else begin
              iAck_q   <= !(cancel_q || flush);
              iRdata_q <= mem_rdata;
            end
          end
        end
        RESP: begin
          iAck_q   <= 1'b0;
          dAck_q   <= 1'b0;
          cancel_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ack     = iAck_q;
  assign d_ack     = dAck_q;
  assign i_rdata   = iRdata_q;
  assign d_rdata   = dRdata_q;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic, checked against a timestamp-based transaction model.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        flush;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction model: one access in flight, described by its grant and ready cycles.
  bit          m_active = 0;
  int          g_cyc = -10;
  int          r_cyc = -10;
  bit          m_data;
  bit          m_we;
  bit          m_cancel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  int          streak = 0;
  int          next_lat = 0;
  bit          i_drop = 0;
  bit          d_drop = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .flush    (flush),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_i_ack"}, i_ack, 0);
    check({tag, "_d_ack"}, d_ack, 0);
    check({tag, "_i_rdata"}, i_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Expected outputs follow from timestamps: memory busy g+1..r, ack at r+1.
  task automatic checkOutput();
    bit eReq, eAck, eBusy, eI, eD;
    eReq  = m_active && cyc > g_cyc && cyc <= r_cyc;
    eAck  = m_active && cyc == r_cyc + 1;
    eBusy = m_active && cyc > g_cyc && cyc <= r_cyc + 1;
    eI    = eAck && !m_data && !m_cancel;
    eD    = eAck && m_data;
    check("mem_req", mem_req, eReq);
    check("busy", busy, eBusy);
    check("i_ack", i_ack, eI);
    check("d_ack", d_ack, eD);
    if (eReq) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_we", mem_we, m_we);
      if (m_data) check("mem_wdata", mem_wdata, m_wdata);
    end
    if (eI) check("i_rdata", i_rdata, m_rdata);
    if (eD) check("d_rdata", d_rdata, m_we ? 32'h0 : m_rdata);
    if (eI) i_drop = 1;
    if (eD) d_drop = 1;
  endtask

  task automatic handleDrops();
    if (d_drop) begin d_req = 0; d_drop = 0; end
    if (i_drop) begin i_req = 0; i_drop = 0; end
  endtask

  // Drives the memory for the current cycle, advances the model, then checks the next cycle.
  task automatic runCycle();
    int lat;
    bit gData, gIf, forceIf, ifPend;
    if (m_active && cyc == r_cyc) begin
      mem_ready = 1; mem_rdata = m_rdata;
    end else if (m_active && cyc > g_cyc && cyc < r_cyc) begin
      mem_ready = 0; mem_rdata = $urandom;
    end else begin
      mem_ready = ($urandom_range(0, 1) == 1); mem_rdata = $urandom;
    end
    if (m_active && !m_data && flush && cyc > g_cyc && cyc <= r_cyc) m_cancel = 1;
    if (m_active && cyc >= r_cyc + 2) m_active = 0;
    if (!m_active) begin
      ifPend  = i_req && !flush;
      forceIf = ifPend && streak >= LIM;
      gData   = d_req && !forceIf;
      gIf     = !gData && ifPend;
      if (gData && ifPend) streak = (streak < LIM) ? streak + 1 : LIM;
      else if (gIf || !i_req) streak = 0;
      if (gData || gIf) begin
        lat      = (next_lat > 0) ? next_lat : $urandom_range(1, 4);
        next_lat = 0;
        m_active = 1;
        g_cyc    = cyc;
        r_cyc    = cyc + lat;
        m_data   = gData;
        m_we     = gData && d_we;
        m_addr   = gData ? d_addr : i_addr;
        m_wdata  = d_wdata;
        m_rdata  = $urandom;
        m_cancel = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic tick();
    handleDrops();
    runCycle();
  endtask

  task automatic applyStimulus();
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1; d_we = ($urandom_range(0, 1) == 1); d_addr = $urandom; d_wdata = $urandom;
    end
    if (!i_req && $urandom_range(0, 1) == 0) begin
      i_req = 1; i_addr = $urandom;
    end
    flush = ($urandom_range(0, 9) == 0);
    if (flush && i_req) i_drop = 1;
  endtask

  task automatic drain();
    int n = 0;
    bit pending;
    flush = 0;
    pending = (m_active && cyc < r_cyc + 2) || i_req || d_req;
    while (pending && n < 60) begin
      tick();
      n++;
      pending = (m_active && cyc < r_cyc + 2) || i_req || d_req;
    end
    checks++;
    assert (!pending)
    else begin
      failures++;
      $error("[TB] FAIL drain_timeout observed=pending expected=idle after %0d cycles", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] seq;
    int nAcks;
    bit iSeen;

    reset = 1; i_req = 0; i_addr = 0; flush = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 0;
    cyc = 0;

    // Single fetch: granted in cycle 0, memory ready in cycle 1, ack in cycle 2.
    i_req = 1; i_addr = 32'h40; next_lat = 1;
    tick();
    m_rdata = 32'h00500093;
    check("single_mem_req", mem_req, 1);
    tick();
    check("single_i_ack", i_ack, 1);
    check("single_i_rdata", i_rdata, 32'h00500093);
    tick();
    check("single_idle", busy, 0);
    drain();

    // Collision: data read wins, the fetch goes out once data has turned around.
    i_req = 1; i_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h100; next_lat = 2;
    tick();
    check("coll_first_addr", mem_addr, 32'h100);
    tick(); tick();
    check("coll_d_ack", d_ack, 1);
    next_lat = 2;
    tick(); tick();
    check("coll_fetch_req", mem_req, 1);
    check("coll_fetch_addr", mem_addr, 32'h44);
    drain();

    // Write: we and wdata held through WAIT, read data returned as zero.
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; next_lat = 2;
    tick();
    check("wr_we_1", mem_we, 1);
    check("wr_wdata_1", mem_wdata, 32'hDEADBEEF);
    tick();
    check("wr_we_2", mem_we, 1);
    check("wr_wdata_2", mem_wdata, 32'hDEADBEEF);
    tick();
    check("wr_d_ack", d_ack, 1);
    check("wr_d_rdata", d_rdata, 0);
    drain();
    d_we = 0;

    // Flush in the second WAIT cycle of a fetch suppresses its ack.
    i_req = 1; i_addr = 32'h48; next_lat = 3; iSeen = 0;
    tick();
    tick();
    flush = 1; i_drop = 1;
    tick();
    iSeen |= i_ack;
    flush = 0;
    tick();
    iSeen |= i_ack;
    check("flush_mem_req_done", mem_req, 0);
    tick();
    iSeen |= i_ack;
    check("flush_busy", busy, 0);
    check("flush_no_i_ack", iSeen, 0);
    drain();

    // Starvation: data held continuously alongside a fetch.
    i_req = 1; i_addr = 32'h4C; seq = '0; nAcks = 0;
    for (int n = 0; n < 80 && nAcks < 6; n++) begin
      handleDrops();
      if (!d_req) begin d_req = 1; d_we = 0; d_addr = $urandom; end
      runCycle();
      if (d_ack) begin seq = {seq[4:0], 1'b1}; nAcks++; end
      if (i_ack) begin seq = {seq[4:0], 1'b0}; nAcks++; end
    end
    check("starve_ack_count", nAcks, 6);
    check("starve_sequence", seq, 6'b111101);
    d_drop = 1;
    drain();

    // Asynchronous reset in the middle of a data access.
    d_req = 1; d_we = 0; d_addr = 32'h300; next_lat = 4;
    tick(); tick();
    check("rst_pre_busy", busy, 1);
    #2 reset = 1;
    #1;
    checkAllZero("rst_async");
    m_active = 0; streak = 0; d_req = 0; i_req = 0; d_drop = 0; i_drop = 0;
    @(posedge clk);
    #1;
    cyc++;
    checkAllZero("rst_held");
    reset = 0;
    repeat (4) tick();
    i_req = 1; i_addr = 32'h80; next_lat = 1;
    tick();
    check("rst_regrant_req", mem_req, 1);
    check("rst_regrant_addr", mem_addr, 32'h80);
    drain();

    // Randomized traffic with flushes and spurious mem_ready.
    for (int n = 0; n < 1500; n++) begin
      handleDrops();
      applyStimulus();
      runCycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
